// File: rtl/divider_controller.sv
// Sequencing FSM for an iterative unsigned restoring divider.
// Decodes state into X/Y/R load enables and mux selects; no arithmetic.
module divider_controller #(
  parameter int ITER = 4,
  parameter int CW   = 3
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          y_zero,
  input  logic          r_ge_y,
  output logic          x_ld,
  output logic [1:0]    x_sel,
  output logic          y_ld,
  output logic          r_ld,
  output logic [1:0]    r_sel,
  output logic [CW-1:0] cnt,
  output logic          busy,
  output logic          done,
  output logic          err
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_CHECK = 3'd2,
    S_SHIFT = 3'd3,
    S_TEST  = 3'd4,
    S_DONE  = 3'd5,
    S_ERR   = 3'd6
  } state_t;

  localparam logic [CW-1:0] LAST = CW'(ITER);
  localparam logic [CW-1:0] ONE  = CW'(1);

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_IDLE:  if (start) state_d = S_LOAD;
      S_LOAD: begin
        cnt_d   = '0;
        state_d = S_CHECK;
      end
      S_CHECK: state_d = y_zero ? S_ERR : S_SHIFT;
      S_SHIFT: begin
        cnt_d   = cnt_q + ONE;
        state_d = S_TEST;
      end
      S_TEST:  state_d = (cnt_q == LAST) ? S_DONE : S_SHIFT;
      S_DONE:  if (!start) state_d = S_IDLE;
      S_ERR:   if (!start) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Datapath controls follow the state register directly; TEST adds r_ge_y.
  always_comb begin
    x_ld  = 1'b0;
    x_sel = 2'b00;
    y_ld  = 1'b0;
    r_ld  = 1'b0;
    r_sel = 2'b00;
    busy  = 1'b0;
    done  = 1'b0;
    err   = 1'b0;
    unique case (state_q)
      S_LOAD: begin
        busy = 1'b1;
        x_ld = 1'b1;
        y_ld = 1'b1;
        r_ld = 1'b1;
      end
      S_CHECK: busy = 1'b1;
      S_SHIFT: begin
        busy  = 1'b1;
        x_ld  = 1'b1;
        x_sel = 2'b01;
        r_ld  = 1'b1;
        r_sel = 2'b01;
      end
      S_TEST: begin
        busy = 1'b1;
        if (r_ge_y) begin
          x_ld  = 1'b1;
          x_sel = 2'b10;
          r_ld  = 1'b1;
          r_sel = 2'b10;
        end
      end
      S_DONE:  done = 1'b1;
      S_ERR:   err  = 1'b1;
      default: ;
    endcase
  end

  assign cnt = cnt_q;

endmodule

// File: tb/tb_divider_controller.sv
// Bench for divider_controller: behavioural X/Y/R datapath around the
// FSM, expectations derived from integer division and the cycle schedule.
module tb_divider_controller;

  localparam int ITER = 4;
  localparam int CW   = 3;

  // {busy,done,err,x_ld,x_sel,y_ld,r_ld,r_sel}
  localparam logic [9:0] V_IDLE  = 10'b0000000000;
  localparam logic [9:0] V_LOAD  = 10'b1001001100;
  localparam logic [9:0] V_CHECK = 10'b1000000000;
  localparam logic [9:0] V_SHIFT = 10'b1001010101;
  localparam logic [9:0] V_TFIRE = 10'b1001100110;
  localparam logic [9:0] V_TNONE = 10'b1000000000;
  localparam logic [9:0] V_DONE  = 10'b0100000000;
  localparam logic [9:0] V_ERR   = 10'b0010000000;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic          y_zero, r_ge_y;
  logic          x_ld, y_ld, r_ld;
  logic [1:0]    x_sel, r_sel;
  logic [CW-1:0] cnt;
  logic          busy, done, err;
  logic [9:0]    outs;

  logic [ITER-1:0] dvd = '0;
  logic [ITER-1:0] dvs = '0;
  logic [ITER-1:0] x_r = '0;
  logic [ITER-1:0] y_r = '0;
  logic [ITER-1:0] r_r = '0;

  int n_cmp = 0;
  int n_bad = 0;

  divider_controller #(.ITER(ITER), .CW(CW)) dut (
    .clk(clk), .reset(reset), .start(start),
    .y_zero(y_zero), .r_ge_y(r_ge_y),
    .x_ld(x_ld), .x_sel(x_sel), .y_ld(y_ld),
    .r_ld(r_ld), .r_sel(r_sel), .cnt(cnt),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  assign outs   = {busy, done, err, x_ld, x_sel, y_ld, r_ld, r_sel};
  assign y_zero = (y_r == '0);
  assign r_ge_y = (r_r >= y_r);

  always @(posedge clk) begin
    if (x_ld) begin
      case (x_sel)
        2'b00:   x_r <= dvd;
        2'b01:   x_r <= {x_r[ITER-2:0], 1'b0};
        2'b10:   x_r <= x_r | 1;
        default: x_r <= 'x;
      endcase
    end
    if (y_ld) y_r <= dvs;
    if (r_ld) begin
      case (r_sel)
        2'b00:   r_r <= '0;
        2'b01:   r_r <= {r_r[ITER-2:0], x_r[ITER-1]};
        2'b10:   r_r <= r_r - y_r;
        default: r_r <= 'x;
      endcase
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic run_division(input logic [ITER-1:0] a,
                              input logic [ITER-1:0] b,
                              input bit toggle, input bit hold);
    logic [9:0] ex;
    int q, rm, last, k;
    q  = (b == 0) ? 0 : int'(a) / int'(b);
    rm = (b == 0) ? 0 : int'(a) % int'(b);
    last = (b == 0) ? 2 : 2 * ITER + 2;
    dvd = a;
    dvs = b;
    start = 1'b1;
    tick;
    n_cmp++;
    if (outs !== V_LOAD) begin
      n_bad++;
      $display("FAIL load %0d/%0d: got %b want %b", a, b, outs, V_LOAD);
    end
    for (int e = 1; e <= last; e++) begin
      if (!hold)
        start = (toggle && e < last - 1) ? 1'($urandom_range(0, 1)) : 1'b0;
      tick;
      k = (e - 1) / 2;
      if (e == 1) ex = V_CHECK;
      else if (e == last) ex = (b == 0) ? V_ERR : V_DONE;
      else if (e % 2 == 0) ex = V_SHIFT;
      else ex = (((q >> (ITER - k)) & 1) != 0) ? V_TFIRE : V_TNONE;
      n_cmp++;
      if (outs !== ex) begin
        n_bad++;
        $display("FAIL seq %0d/%0d edge %0d: got %b want %b",
                 a, b, e, outs, ex);
      end
      n_cmp++;
      if (cnt !== CW'(k)) begin
        n_bad++;
        $display("FAIL cnt %0d/%0d edge %0d: got %0d want %0d",
                 a, b, e, cnt, k);
      end
    end
    if (b != 0) begin
      n_cmp++;
      if (x_r !== ITER'(q) || r_r !== ITER'(rm)) begin
        n_bad++;
        $display("FAIL result %0d/%0d: got q=%0d r=%0d want q=%0d r=%0d",
                 a, b, x_r, r_r, q, rm);
      end
    end else begin
      n_cmp++;
      if (x_r !== a || y_r !== '0 || r_r !== '0) begin
        n_bad++;
        $display("FAIL errregs %0d/0: got x=%0d y=%0d r=%0d want x=%0d y=0 r=0",
                 a, x_r, y_r, r_r, a);
      end
    end
  endtask

  task automatic return_idle;
    start = 1'b0;
    tick;
    n_cmp++;
    if (outs !== V_IDLE) begin
      n_bad++;
      $display("FAIL idle: got %b want %b", outs, V_IDLE);
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    start = 1'b0;
    tick;
    tick;
    n_cmp++;
    if (outs !== V_IDLE) begin
      n_bad++;
      $display("FAIL reset_outs: got %b want %b", outs, V_IDLE);
    end
    n_cmp++;
    if (cnt !== '0) begin
      n_bad++;
      $display("FAIL reset_cnt: got %0d want 0", cnt);
    end
    reset = 1'b0;
    tick;
    n_cmp++;
    if (outs !== V_IDLE) begin
      n_bad++;
      $display("FAIL idle_nostart: got %b want %b", outs, V_IDLE);
    end
  endtask

  task automatic test_directed;
    run_division(4'd13, 4'd4, 1'b0, 1'b0);
    return_idle;
    run_division(4'd15, 4'd1, 1'b0, 1'b0);
    return_idle;
    run_division(4'd0, 4'd7, 1'b0, 1'b0);
    return_idle;
  endtask

  task automatic test_div_zero;
    run_division(4'd9, 4'd0, 1'b0, 1'b1);
    tick;
    n_cmp++;
    if (outs !== V_ERR) begin
      n_bad++;
      $display("FAIL err_hold: got %b want %b", outs, V_ERR);
    end
    return_idle;
  endtask

  task automatic test_held_start;
    run_division(4'd11, 4'd3, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) begin
      tick;
      n_cmp++;
      if (outs !== V_DONE) begin
        n_bad++;
        $display("FAIL done_hold %0d: got %b want %b", i, outs, V_DONE);
      end
    end
    return_idle;
    start = 1'b1;
    tick;
    n_cmp++;
    if (outs !== V_LOAD) begin
      n_bad++;
      $display("FAIL restart_load: got %b want %b", outs, V_LOAD);
    end
    start = 1'b0;
    reset = 1'b1;
    tick;
    reset = 1'b0;
  endtask

  task automatic test_reset_mid;
    dvd = 4'd12;
    dvs = 4'd5;
    start = 1'b1;
    tick;
    start = 1'b0;
    for (int e = 1; e <= 6; e++) tick;
    n_cmp++;
    if (outs !== V_SHIFT) begin
      n_bad++;
      $display("FAIL shift3: got %b want %b", outs, V_SHIFT);
    end
    reset = 1'b1;
    tick;
    reset = 1'b0;
    n_cmp++;
    if (outs !== V_IDLE || cnt !== '0) begin
      n_bad++;
      $display("FAIL reset_mid: got %b cnt=%0d want %b cnt=0",
               outs, cnt, V_IDLE);
    end
    run_division(4'd6, 4'd3, 1'b0, 1'b0);
    return_idle;
  endtask

  task automatic test_random;
    logic [ITER-1:0] a, b;
    for (int i = 0; i < 24; i++) begin
      a = ITER'($urandom_range(0, 15));
      b = ITER'($urandom_range(0, 15));
      run_division(a, b, 1'b1, 1'b0);
      return_idle;
    end
  endtask

  initial begin
    test_reset;
    test_directed;
    test_div_zero;
    test_held_start;
    test_reset_mid;
    test_random;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
